uart_tx_ctrl: RTL

Frame sequencer for the UART transmitter. Accepts a parallel byte over a valid/ack handshake, latches it, and steps a start/data/parity/stop state machine paced by the baud tick. It drives the select of the registered 4:1 output mux and supplies that mux's serial-data and parity inputs. Sits between the TX data source and the output mux; the mux's registered output is the TX line.

---
 rtl/uart_tx_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start/data/parity/stop, paced by TICK.
// Define UART_TX_PARITY_EN to compile in the optional parity bit.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  DATA_ACK,
    output logic [1:0]            MUX_SEL,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic                  BUSY
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd5
    } state_t;
`endif

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] sh_q;
    logic [DATA_WIDTH-1:0] sh_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  ser_q;
    logic                  ser_d;
    logic [1:0]            mux_q;
    logic [1:0]            mux_d;
    logic                  busy_q;
    logic                  accept;

`ifdef UART_TX_PARITY_EN
    logic                  par_q;
    logic                  par_d;
    logic                  pen_q;
    logic                  pen_d;
`else
    logic                  unused_par;
`endif

    // A word is taken from IDLE, or on the closing STOP tick for back-to-back frames
    assign accept   = DATA_VALID & ((state_q == IDLE) |
                                    ((state_q == STOP) & TICK));
    assign DATA_ACK = accept & RST;

    assign MUX_SEL  = mux_q;
    assign SER_DATA = ser_q;
    assign BUSY     = busy_q;

`ifdef UART_TX_PARITY_EN
    assign PAR_BIT    = par_q;
`else
    assign PAR_BIT    = 1'b0;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            mux_q   <= MUX_STOP;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            mux_q   <= mux_d;
            busy_q  <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
            pen_q   <= pen_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        mux_d   = mux_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
        pen_d   = pen_q;
`endif

        if (accept) begin
            sh_d  = P_DATA;
`ifdef UART_TX_PARITY_EN
            pen_d = PAR_EN;
            par_d = (^P_DATA) ^ PAR_TYP;
`endif
        end

        unique case (state_q)
            IDLE: begin
                mux_d = MUX_STOP;
                if (accept) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (TICK) begin
                    state_d = START;
                    mux_d   = MUX_START;
                end
            end
            START: begin
                if (TICK) begin
                    state_d = DATA;
                    mux_d   = MUX_DATA;
                    ser_d   = sh_q[0];
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (TICK) begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        if (pen_q) begin
                            state_d = PARITY;
                            mux_d   = MUX_PAR;
                        end else begin
                            state_d = STOP;
                            mux_d   = MUX_STOP;
                        end
`else
                        state_d = STOP;
                        mux_d   = MUX_STOP;
`endif
                    end else begin
                        // LSB first: bit 0 already on the line, shift up the next one
                        sh_d  = sh_q >> 1;
                        ser_d = sh_q[1];
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (TICK) begin
                    state_d = STOP;
                    mux_d   = MUX_STOP;
                end
            end
`endif
            STOP: begin
                if (TICK) begin
                    if (accept) begin
                        state_d = START;
                        mux_d   = MUX_START;
                    end else begin
                        state_d = IDLE;
                        mux_d   = MUX_STOP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mux_d   = MUX_STOP;
            end
        endcase
    end

endmodule
